fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Sequences the instruction-fetch datapath: owns the fetch PC, drives the instruction bus request and holds it stable until `data_ok`.
- Buffers one fetched instruction for decode and handles redirects (branch/jump/exception).
- A redirect that arrives while a bus transaction is in flight does not abort the transaction. The transaction completes and its response is discarded.
- Sits between the ibus port and the F/D pipeline register, replacing ad-hoc PC/valid logic in the fetch stage.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- ireq  output  ibus_req_t  instruction bus request (valid, addr)
- iresp  input  ibus_resp_t  instruction bus response (addr_ok, data_ok, data)
- redirect_valid  input  1  redirect fetch to redirect_pc this cycle
- redirect_pc  input  64  redirect target
- stall  input  1  downstream cannot accept the buffered instruction this cycle
- out_valid  output  1  out_pc/out_instr hold a valid instruction
- out_pc  output  64  PC of buffered instruction
- out_instr  output  32  buffered instruction word
- discard_cnt  output  32  number of bus responses dropped due to redirect

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `reset`.
- Registers:
  - state ∈ {REQ, WAIT_ACCEPT, DISCARD}
  - fetch_addr (64): address on the bus
  - next_pc (64): target held during DISCARD
  - out_valid, out_pc, out_instr
  - discard_cnt
- Bus drive: ireq.addr = fetch_addr always. ireq.valid = (state==REQ or state==DISCARD) and !reset.
- Bus rule: once ireq.valid rises, valid and addr stay constant until the cycle where iresp.data_ok=1.
- Reset values:
  - state=REQ, fetch_addr=RESET_PC, next_pc=RESET_PC
  - out_valid=0, out_pc=0, out_instr=0, discard_cnt=0
  - ireq.valid=0 during the reset cycle.
- REQ:
  - data_ok & redirect_valid: response dropped; discard_cnt+=1; fetch_addr<=redirect_pc; stay REQ.
  - data_ok & !redirect_valid: out_instr<=iresp.data, out_pc<=fetch_addr, out_valid<=1, fetch_addr<=fetch_addr+PC_STEP; go to WAIT_ACCEPT.
  - !data_ok & redirect_valid: next_pc<=redirect_pc; go to DISCARD. fetch_addr is unchanged.
  - !data_ok & !redirect_valid: hold.
- WAIT_ACCEPT:
  - ireq.valid=0.
  - redirect_valid: out_valid<=0, fetch_addr<=redirect_pc; go to REQ. Redirect has priority over stall.
  - else !stall: out_valid<=0; go to REQ. The instruction is consumed this cycle.
  - else: hold all outputs.
- DISCARD:
  - redirect_valid: next_pc<=redirect_pc; the latest redirect wins.
  - data_ok: response dropped; discard_cnt+=1; fetch_addr<=(redirect_valid ? redirect_pc : next_pc); go to REQ.
- out_valid is 0 in REQ and DISCARD. Decode consumes only when out_valid & !stall.
- Latency:
  - Sequential fetch costs the bus latency plus a one-cycle issue bubble after acceptance.
  - A zero-wait bus (data_ok in the same cycle as valid) gives one instruction per 2 cycles.
- Arithmetic:
  - fetch_addr+PC_STEP wraps modulo 2^64.
  - redirect_pc is used unchecked; alignment faults are detected elsewhere.
  - discard_cnt wraps at 2^32.
- iresp.addr_ok is ignored. The handshake is data_ok only.
- Reset mid-transaction: the state returns to REQ at RESET_PC. The bus must tolerate abandonment on reset.

Test Plan:
- Reset, then zero-wait bus returning 32'h0000_0013 on each request, stall=0:
  - ireq.addr sequence is 8000_0000, 8000_0004, 8000_0008.
  - out_valid pulses every 2nd cycle with matching out_pc.
  - discard_cnt=0.
- Bus with 3-cycle data_ok latency; redirect_valid=1, redirect_pc=8000_0100 in the 2nd wait cycle:
  - ireq stays at 8000_0000 with valid=1 until data_ok.
  - No out_valid is produced.
  - Next request goes to 8000_0100.
  - discard_cnt=1.
- Two redirects (8000_0200, then 8000_0300) during one DISCARD: next fetch address is 8000_0300; discard_cnt increments by 1.
- Instruction buffered, stall=1 for 4 cycles:
  - out_valid, out_pc and out_instr stay constant.
  - ireq.valid=0 throughout.
  - After stall drops, out_valid falls next cycle and the next fetch issues.
- Redirect coincident with data_ok in REQ: response dropped, fetch_addr = redirect target next cycle, discard_cnt+=1. Redirect while stalled in WAIT_ACCEPT: out_valid clears.
- Assert reset during an outstanding request: next cycle after release, ireq.addr=RESET_PC, out_valid=0, discard_cnt=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives a data_ok-handshaked
// instruction bus, buffers one instruction for decode and absorbs redirects.
package fetch_ctrl_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;
endpackage

module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [63:0] PC_STEP  = 64'd4
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] discard_cnt
);

    typedef enum logic [1:0] {
        S_REQ         = 2'd0,
        S_WAIT_ACCEPT = 2'd1,
        S_DISCARD     = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] fetch_addr_q, fetch_addr_d;
    logic [63:0] next_pc_q, next_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] discard_cnt_q, discard_cnt_d;

    // The handshake is data_ok only; addr_ok is deliberately not consulted.
    logic        unused_addr_ok;
    assign unused_addr_ok = iresp.addr_ok;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_REQ;
            fetch_addr_q  <= RESET_PC;
            next_pc_q     <= RESET_PC;
            out_valid_q   <= 1'b0;
            out_pc_q      <= 64'd0;
            out_instr_q   <= 32'd0;
            discard_cnt_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            next_pc_q     <= next_pc_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_instr_q   <= out_instr_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    // Next-state logic; an in-flight bus transaction is never aborted, only drained.
    always_comb begin
        state_d       = state_q;
        fetch_addr_d  = fetch_addr_q;
        next_pc_d     = next_pc_q;
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_instr_d   = out_instr_q;
        discard_cnt_d = discard_cnt_q;
        case (state_q)
            S_REQ: begin
                if (iresp.data_ok) begin
                    if (redirect_valid) begin
                        discard_cnt_d = discard_cnt_q + 32'd1;
                        fetch_addr_d  = redirect_pc;
                    end else begin
                        out_instr_d  = iresp.data;
                        out_pc_d     = fetch_addr_q;
                        out_valid_d  = 1'b1;
                        fetch_addr_d = fetch_addr_q + PC_STEP;
                        state_d      = S_WAIT_ACCEPT;
                    end
                end else if (redirect_valid) begin
                    next_pc_d = redirect_pc;
                    state_d   = S_DISCARD;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT_ACCEPT: begin
                // Redirect outranks stall: the buffered instruction is squashed.
                if (redirect_valid) begin
                    out_valid_d  = 1'b0;
                    fetch_addr_d = redirect_pc;
                    state_d      = S_REQ;
                end else if (!stall) begin
                    out_valid_d = 1'b0;
                    state_d     = S_REQ;
                end else begin
                    state_d = S_WAIT_ACCEPT;
                end
            end
            S_DISCARD: begin
                if (redirect_valid) begin
                    next_pc_d = redirect_pc;
                end else begin
                    next_pc_d = next_pc_q;
                end
                if (iresp.data_ok) begin
                    discard_cnt_d = discard_cnt_q + 32'd1;
                    fetch_addr_d  = redirect_valid ? redirect_pc : next_pc_q;
                    state_d       = S_REQ;
                end else begin
                    state_d = S_DISCARD;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Bus request: address always mirrors fetch_addr, valid suppressed during reset.
    always_comb begin
        ireq.addr  = fetch_addr_q;
        ireq.valid = ((state_q == S_REQ) || (state_q == S_DISCARD)) && !reset;
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_instr   = out_instr_q;
    assign discard_cnt = discard_cnt_q;

endmodule
